fx2_slave_fifo_emu: RTL and testbench
=====================================

Name: fx2_slave_fifo_emu

Overview:
- Synthesizable emulator of the Cypress FX2 endpoint side of the Slave FIFO interface; the counterpart of the FPGA-side high-speed I/O controller.
- Answers SLRD/SLWR/SLOE/FIFOADR/PKTEND, drives FLAGB/FLAGC and the read data.
- Two endpoint buffers, with a simple FIFO port on the host side for each:
  - EP6: host to FPGA.
  - EP2: FPGA to host, packet-committed.
- Used for loopback builds and for closed-loop verification of the I/O path without a USB controller.

Parameters:
- EP6_DEPTH_LOG2, 11, log2 of EP6 buffer depth in 16-bit words.
- EP2_DEPTH_LOG2, 11, log2 of EP2 buffer depth in 16-bit words.
- PKT_WORDS, 256, EP2 auto-commit packet size in words (512 bytes); must divide 2**EP2_DEPTH_LOG2.

Ports:
- IFCLK  in  1  interface clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- FIFOADR  in  2  endpoint select: 2'b00 = EP2, 2'b10 = EP6, other values select no endpoint.
- SLOE  in  1  active-low output enable for read data.
- SLRD  in  1  active-low read strobe.
- SLWR  in  1  active-low write strobe.
- PKTEND  in  1  active-low commit of a short EP2 packet.
- fifo_din  in  16  data written by the FPGA.
- fifo_dout  out  16  EP6 head word.
- fifo_oe  out  1  enable for the external tristate driver.
- FLAGB  out  1  active-low EP2 full.
- FLAGC  out  1  active-low EP6 empty.
- host_din  in  16  host word for EP6.
- host_wr_en  in  1  push into EP6.
- host_full  out  1  EP6 full.
- host_dout  out  16  EP2 head word; registered.
- host_rd_en  in  1  pop from EP2.
- host_empty  out  1  no committed EP2 word.
- err_underflow  out  1  sticky error flag.
- err_overflow  out  1  sticky error flag.
- pkt_cnt  out  16  count of committed EP2 packets; wraps.

Behaviour:
- Reset (async assert, sync release):
  - All pointers and counters cleared.
  - FLAGB = 1, FLAGC = 0, host_full = 0, host_empty = 1.
  - fifo_oe = 0, fifo_dout = 0, host_dout = 0, errors = 0, pkt_cnt = 0.
  - Reset mid-packet discards all buffered and uncommitted data.
- Strobe validity: a strobe is valid only when it is sampled low at an IFCLK edge and FIFOADR selects the matching endpoint:
  - SLRD: EP6.
  - SLWR and PKTEND: EP2.
  - Strobes with any other FIFOADR are ignored, with no error.
- fifo_oe = ~SLOE & (FIFOADR == 2'b10); combinational.
- fifo_dout always shows the EP6 head word from RAM read-ahead (zero when empty).
- EP6 read:
  - Valid SLRD with EP6 non-empty: pop; the next word is on fifo_dout in the following cycle.
  - Valid SLRD with EP6 empty: no pop; err_underflow is set.
- EP6 write (host side):
  - host_wr_en with host_full = 0: push.
  - host_wr_en with host_full = 1: word dropped; err_overflow is set.
- EP6 simultaneous pop and push: occupancy unchanged. A push into an empty buffer is visible on fifo_dout one cycle later.
- EP2 write:
  - Valid SLWR with EP2 not full: write fifo_din at wr_ptr.
  - Valid SLWR with EP2 full: word dropped; err_overflow is set.
- EP2 commit:
  - commit_ptr advances to wr_ptr when the uncommitted count reaches PKT_WORDS, or on a valid PKTEND.
  - PKTEND with SLWR in the same cycle includes that word in the commit.
  - PKTEND with 0 uncommitted words: nothing is committed, but pkt_cnt still increments (zero-length packet).
  - Every commit increments pkt_cnt by 1.
- EP2 host read:
  - host_empty = (rd_ptr == commit_ptr).
  - host_rd_en while non-empty: pop. host_dout is registered and shows the head word; the updated head appears the cycle after the pop.
  - host_rd_en while empty: ignored, no error.
- Flags are registered and reflect state after the current edge's events, so FLAGB and FLAGC lag a strobe by exactly 1 cycle:
  - FLAGB = 0 when EP2 occupancy (wr_ptr − rd_ptr) == 2**EP2_DEPTH_LOG2.
  - FLAGC = 0 when EP6 is empty.
- Pointers:
  - Pointers are one bit wider than the address, so full and empty are distinguished at wrap-around.
  - Counters wrap modulo 2**(LOG2+1).

Test Plan:
- Push 0x0001..0x0004 via host_wr_en, FIFOADR=10, SLOE=0, SLRD low 4 cycles -> fifo_dout sequence 0x0001..0x0004, fifo_oe=1, FLAGC=0 one cycle after the fourth pop, err_underflow=0.
- SLRD low once more on the empty EP6 -> err_underflow=1, no pointer change; FIFOADR=01 with SLRD low -> ignored.
- FIFOADR=00, 256 SLWR writes of 0xA000+n -> pkt_cnt=1 after the 256th write, host_empty=0, host reads return 0xA000..0xA0FF.
- 3 SLWR writes then PKTEND together with a 4th -> 4 words committed, pkt_cnt increments; PKTEND alone with nothing pending -> pkt_cnt +1, host_empty stays 1.
- Fill EP2 to 2048 words without host reads -> FLAGB=0 one cycle after the last write; an extra SLWR sets err_overflow and the word is lost; one host read -> FLAGB=1 next cycle.
- Assert RESET_N=0 asynchronously mid-packet with EP6 partly full -> outputs take reset values immediately; after release EP6 reads as empty and pkt_cnt=0.

Source files
------------

// File: rtl/fx2_slave_fifo_emu_if.sv
// fx2_slave_fifo_emu_if: FX2 slave-FIFO pins plus host-side EP6/EP2 FIFO ports
// slave  : the endpoint emulator (answers strobes, drives flags/data, serves host ports)
// master : the FPGA I/O controller and host model driving strobes and host FIFO ports
interface fx2_slave_fifo_emu_if;
  logic [1:0] FIFOADR;
  logic SLOE, SLRD, SLWR, PKTEND;
  logic [15:0] fifo_din, fifo_dout;
  logic fifo_oe, FLAGB, FLAGC;
  logic [15:0] host_din, host_dout;
  logic host_wr_en, host_full, host_rd_en, host_empty;
  logic err_underflow, err_overflow;
  logic [15:0] pkt_cnt;
  modport slave (
    input FIFOADR, SLOE, SLRD, SLWR, PKTEND, fifo_din, host_din, host_wr_en, host_rd_en,
    output fifo_dout, fifo_oe, FLAGB, FLAGC, host_full, host_dout, host_empty,
    output err_underflow, err_overflow, pkt_cnt
  );
  modport master (
    output FIFOADR, SLOE, SLRD, SLWR, PKTEND, fifo_din, host_din, host_wr_en, host_rd_en,
    input fifo_dout, fifo_oe, FLAGB, FLAGC, host_full, host_dout, host_empty,
    input err_underflow, err_overflow, pkt_cnt
  );
endinterface

// File: rtl/fx2_slave_fifo_emu.sv
// fx2_slave_fifo_emu: Cypress FX2 slave-FIFO endpoint emulator (EP6 host->FPGA, EP2 FPGA->host)
// IFCLK   : interface clock, rising edge
// RESET_N : asynchronous active-low reset
// bus     : FX2 strobes/flags/data (SLRD, SLWR, SLOE, PKTEND, FIFOADR, FLAGB, FLAGC,
//           fifo_din/dout, fifo_oe), host EP6 push port, host EP2 pop port, errors, pkt_cnt
module fx2_slave_fifo_emu #(
  parameter int EP6_DEPTH_LOG2 = 11,
  parameter int EP2_DEPTH_LOG2 = 11,
  parameter int PKT_WORDS = 256
) (
  input logic IFCLK,
  input logic RESET_N,
  fx2_slave_fifo_emu_if.slave bus
);
  localparam int A6 = EP6_DEPTH_LOG2;
  localparam int A2 = EP2_DEPTH_LOG2;
  localparam logic [A6:0] D6 = {1'b1, {A6{1'b0}}};
  localparam logic [A2:0] D2 = {1'b1, {A2{1'b0}}};
  localparam logic [A2:0] PKT = (A2+1)'(PKT_WORDS);
  logic [15:0] ep6_mem [2**A6];
  logic [15:0] ep2_mem [2**A2];
  logic [A6:0] wr6, rd6, wr6_n, rd6_n;
  logic [A2:0] wr2, rd2, cm2, wr2_n, rd2_n, cm2_n;
  logic slrd_v, slwr_v, pktend_v, empty6, full6, full2;
  logic pop6, push6, wr2_en, pop2, commit;
  logic flagb, flagc, err_u, err_o;
  logic [15:0] host_dout_r, pkt_cnt_r;
  always_comb begin
    slrd_v = ~bus.SLRD & (bus.FIFOADR == 2'b10);
    slwr_v = ~bus.SLWR & (bus.FIFOADR == 2'b00);
    pktend_v = ~bus.PKTEND & (bus.FIFOADR == 2'b00);
    empty6 = wr6 == rd6;
    full6 = (wr6 - rd6) == D6;
    full2 = (wr2 - rd2) == D2;
    pop6 = slrd_v & ~empty6;
    push6 = bus.host_wr_en & ~full6;
    wr2_en = slwr_v & ~full2;
    pop2 = bus.host_rd_en & (rd2 != cm2);
    wr6_n = wr6 + (A6+1)'(push6);
    rd6_n = rd6 + (A6+1)'(pop6);
    wr2_n = wr2 + (A2+1)'(wr2_en);
    rd2_n = rd2 + (A2+1)'(pop2);
    // A full packet only ever forms on a write, so it is committed on that same edge
    commit = pktend_v | ((wr2_n - cm2) == PKT);
    cm2_n = commit ? wr2_n : cm2;
  end
  always_ff @(posedge IFCLK) begin
    if (push6) ep6_mem[wr6[A6-1:0]] <= bus.host_din;
    if (wr2_en) ep2_mem[wr2[A2-1:0]] <= bus.fifo_din;
  end
  always_ff @(posedge IFCLK or negedge RESET_N)
    if (!RESET_N) begin
      wr6 <= '0;
      rd6 <= '0;
      wr2 <= '0;
      rd2 <= '0;
      cm2 <= '0;
      flagb <= 1'b1;
      flagc <= 1'b0;
      host_dout_r <= '0;
      pkt_cnt_r <= '0;
      err_u <= 1'b0;
      err_o <= 1'b0;
    end else begin
      wr6 <= wr6_n;
      rd6 <= rd6_n;
      wr2 <= wr2_n;
      rd2 <= rd2_n;
      cm2 <= cm2_n;
      flagb <= (wr2_n - rd2_n) != D2;
      flagc <= wr6_n != rd6_n;
      // Forward a word written and committed on this edge straight into the head register
      host_dout_r <= (rd2_n == cm2_n) ? '0 :
                     (wr2_en && wr2[A2-1:0] == rd2_n[A2-1:0]) ? bus.fifo_din : ep2_mem[rd2_n[A2-1:0]];
      pkt_cnt_r <= pkt_cnt_r + 16'(commit);
      err_u <= err_u | (slrd_v & empty6);
      err_o <= err_o | (bus.host_wr_en & full6) | (slwr_v & full2);
    end
  assign bus.fifo_oe = ~bus.SLOE & (bus.FIFOADR == 2'b10);
  assign bus.fifo_dout = empty6 ? '0 : ep6_mem[rd6[A6-1:0]];
  assign bus.FLAGB = flagb;
  assign bus.FLAGC = flagc;
  assign bus.host_full = full6;
  assign bus.host_empty = rd2 == cm2;
  assign bus.host_dout = host_dout_r;
  assign bus.err_underflow = err_u;
  assign bus.err_overflow = err_o;
  assign bus.pkt_cnt = pkt_cnt_r;
endmodule

// File: tb/tb_fx2_slave_fifo_emu.sv
// tb_fx2_slave_fifo_emu: directed bench with queue scoreboards for EP6 and EP2
module tb_fx2_slave_fifo_emu;
  logic IFCLK = 1'b0;
  logic RESET_N = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] q6[$];
  logic [15:0] q2[$];
  fx2_slave_fifo_emu_if bus();
  fx2_slave_fifo_emu dut (.IFCLK(IFCLK), .RESET_N(RESET_N), .bus(bus));
  always #5 IFCLK = ~IFCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge IFCLK);
  endtask
  task automatic idle();
    bus.SLRD = 1'b1;
    bus.SLWR = 1'b1;
    bus.PKTEND = 1'b1;
    bus.host_wr_en = 1'b0;
    bus.host_rd_en = 1'b0;
  endtask
  task automatic ep2_write(input logic [15:0] d, input logic pe);
    bus.FIFOADR = 2'b00;
    bus.SLWR = 1'b0;
    bus.PKTEND = ~pe;
    bus.fifo_din = d;
    q2.push_back(d);
    step();
    idle();
  endtask
  task automatic drain2(input string tag);
    while (q2.size() > 0) begin
      chk(tag, bus.host_dout, q2.pop_front());
      bus.host_rd_en = 1'b1;
      step();
    end
    bus.host_rd_en = 1'b0;
    chk({tag, "_empty"}, bus.host_empty, 1);
  endtask
  initial begin
    bus.FIFOADR = 2'b11;
    bus.SLOE = 1'b1;
    bus.fifo_din = '0;
    bus.host_din = '0;
    idle();
    step(2);
    chk("rst_flagb", bus.FLAGB, 1);
    chk("rst_flagc", bus.FLAGC, 0);
    chk("rst_host_full", bus.host_full, 0);
    chk("rst_host_empty", bus.host_empty, 1);
    chk("rst_fifo_oe", bus.fifo_oe, 0);
    chk("rst_fifo_dout", bus.fifo_dout, 0);
    chk("rst_host_dout", bus.host_dout, 0);
    chk("rst_errs", {bus.err_underflow, bus.err_overflow}, 0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 0);
    RESET_N = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      bus.host_wr_en = 1'b1;
      bus.host_din = 16'(i);
      q6.push_back(16'(i));
      step();
    end
    idle();
    chk("flagc_data", bus.FLAGC, 1);
    bus.FIFOADR = 2'b10;
    bus.SLOE = 1'b0;
    #1 chk("fifo_oe", bus.fifo_oe, 1);
    step();
    while (q6.size() > 0) begin
      chk("ep6_data", bus.fifo_dout, q6.pop_front());
      bus.SLRD = 1'b0;
      step();
    end
    bus.SLRD = 1'b1;
    chk("flagc_empty", bus.FLAGC, 0);
    chk("ep6_dout_empty", bus.fifo_dout, 0);
    chk("no_underflow", bus.err_underflow, 0);
    bus.SLRD = 1'b0;
    step();
    bus.SLRD = 1'b1;
    chk("underflow", bus.err_underflow, 1);
    chk("underflow_flagc", bus.FLAGC, 0);
    bus.FIFOADR = 2'b01;
    bus.SLRD = 1'b0;
    bus.host_wr_en = 1'b1;
    bus.host_din = 16'h0005;
    step();
    bus.host_wr_en = 1'b0;
    step(2);
    #1 chk("oe_wrong_adr", bus.fifo_oe, 0);
    chk("ignored_slrd_data", bus.fifo_dout, 16'h0005);
    chk("ignored_slrd_flagc", bus.FLAGC, 1);
    step();
    bus.FIFOADR = 2'b10;
    step();
    idle();
    chk("ep6_popped", bus.FLAGC, 0);
    bus.SLOE = 1'b1;
    for (int n = 0; n < 256; n++) begin
      if (n == 255) begin
        chk("pre_commit_empty", bus.host_empty, 1);
        chk("pre_commit_pkt", bus.pkt_cnt, 0);
      end
      ep2_write(16'hA000 + 16'(n), 1'b0);
    end
    chk("auto_commit_pkt", bus.pkt_cnt, 1);
    chk("auto_commit_nonempty", bus.host_empty, 0);
    drain2("ep2_auto");
    for (int n = 0; n < 3; n++) ep2_write(16'hB000 + 16'(n), 1'b0);
    chk("short_uncommitted", bus.host_empty, 1);
    ep2_write(16'hB003, 1'b1);
    chk("short_pkt", bus.pkt_cnt, 2);
    drain2("ep2_short");
    bus.PKTEND = 1'b0;
    step();
    idle();
    chk("zlp_pkt", bus.pkt_cnt, 3);
    chk("zlp_empty", bus.host_empty, 1);
    ep2_write(16'hC0DE, 1'b1);
    chk("single_pkt", bus.pkt_cnt, 4);
    drain2("ep2_single");
    for (int n = 0; n < 2048; n++) begin
      if (n == 2047) chk("flagb_not_full", bus.FLAGB, 1);
      ep2_write(16'hD000 + 16'(n), 1'b0);
    end
    chk("flagb_full", bus.FLAGB, 0);
    chk("fill_pkt", bus.pkt_cnt, 12);
    chk("no_overflow", bus.err_overflow, 0);
    bus.SLWR = 1'b0;
    bus.fifo_din = 16'hEEEE;
    step();
    idle();
    chk("overflow", bus.err_overflow, 1);
    chk("overflow_flagb", bus.FLAGB, 0);
    chk("full_head", bus.host_dout, q2.pop_front());
    bus.host_rd_en = 1'b1;
    step();
    bus.host_rd_en = 1'b0;
    chk("flagb_released", bus.FLAGB, 1);
    drain2("ep2_fill");
    bus.PKTEND = 1'b0;
    step();
    idle();
    chk("dropped_word_absent", bus.host_empty, 1);
    chk("dropped_pkt", bus.pkt_cnt, 13);
    bus.FIFOADR = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.host_wr_en = 1'b1;
      bus.host_din = 16'h7700 + 16'(i);
      step();
    end
    idle();
    for (int n = 0; n < 5; n++) ep2_write(16'hF000 + 16'(n), 1'b0);
    chk("pre_reset_flagc", bus.FLAGC, 1);
    chk("pre_reset_dout", bus.fifo_dout, 16'h7700);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_flagc", bus.FLAGC, 0);
    chk("arst_flagb", bus.FLAGB, 1);
    chk("arst_fifo_dout", bus.fifo_dout, 0);
    chk("arst_host_empty", bus.host_empty, 1);
    chk("arst_host_dout", bus.host_dout, 0);
    chk("arst_pkt_cnt", bus.pkt_cnt, 0);
    chk("arst_errs", {bus.err_underflow, bus.err_overflow}, 0);
    q2.delete();
    q6.delete();
    step();
    RESET_N = 1'b1;
    step(2);
    chk("post_rst_flagc", bus.FLAGC, 0);
    chk("post_rst_dout", bus.fifo_dout, 0);
    chk("post_rst_pkt", bus.pkt_cnt, 0);
    bus.FIFOADR = 2'b00;
    bus.PKTEND = 1'b0;
    step();
    idle();
    chk("post_rst_zlp_pkt", bus.pkt_cnt, 1);
    chk("post_rst_discard", bus.host_empty, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
